// File: rtl/mod_step_counter.sv
// Up/down counter with runtime modulo limit, programmable step, wrap/saturate mode,
// registered terminal-count / step-error pulses and sticky overflow/underflow flags.
module mod_step_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] data_load,
  input  logic             ce,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] step,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             tc,
  output logic             step_err,
  output logic             ovf_flag,
  output logic             unf_flag
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovf_set, unf_set;

  // One extra bit so sums and max_val+1 never truncate.
  logic [WIDTH:0] cnt_w, step_w, max_w, sum_w, lim_w;

  assign cnt_w  = {1'b0, count_q};
  assign step_w = {1'b0, step};
  assign max_w  = {1'b0, max_val};
  assign sum_w  = cnt_w + step_w;
  assign lim_w  = max_w + 1'b1;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!load_n) begin
      count_d = (data_load > max_val) ? max_val : data_load;
    end else if (ce && (step != '0)) begin
      if (step > max_val) begin
        err_d = 1'b1;
      end else if (count_q > max_val) begin
        // max_val was lowered below the current count.
        if (up_down) begin
          count_d = sat_mode ? max_val : '0;
          tc_d    = 1'b1;
          ovf_set = 1'b1;
        end else begin
          count_d = max_val;
        end
      end else if (up_down) begin
        if (sum_w <= max_w) begin
          count_d = sum_w[WIDTH-1:0];
        end else begin
          count_d = sat_mode ? max_val : WIDTH'(sum_w - lim_w);
          tc_d    = 1'b1;
          ovf_set = 1'b1;
        end
      end else begin
        if (count_q >= step) begin
          count_d = count_q - step;
        end else begin
          count_d = sat_mode ? '0 : WIDTH'(cnt_w + lim_w - step_w);
          tc_d    = 1'b1;
          unf_set = 1'b1;
        end
      end
    end
    // Set wins over a simultaneous clear.
    ovf_d = (ovf_q & ~clr_flags) | ovf_set;
    unf_d = (unf_q & ~clr_flags) | unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_out = count_q;
  assign max_count = (count_q == max_val);
  assign zero      = (count_q == '0);
  assign tc        = tc_q;
  assign step_err  = err_q;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed self-checking bench for mod_step_counter with hand-computed expectations.
module tb_mod_step_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             load_n;
  logic [WIDTH-1:0] data_load;
  logic             ce;
  logic             up_down;
  logic             sat_mode;
  logic [WIDTH-1:0] max_val;
  logic [WIDTH-1:0] step;
  logic             clr_flags;
  logic [WIDTH-1:0] count_out;
  logic             max_count;
  logic             zero;
  logic             tc;
  logic             step_err;
  logic             ovf_flag;
  logic             unf_flag;

  int checks = 0;
  int errors = 0;

  mod_step_counter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_n    (load_n),
    .data_load (data_load),
    .ce        (ce),
    .up_down   (up_down),
    .sat_mode  (sat_mode),
    .max_val   (max_val),
    .step      (step),
    .clr_flags (clr_flags),
    .count_out (count_out),
    .max_count (max_count),
    .zero      (zero),
    .tc        (tc),
    .step_err  (step_err),
    .ovf_flag  (ovf_flag),
    .unf_flag  (unf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    load_n    = 1'b0;
    data_load = v;
    tick();
    load_n    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load_n = 1'b1; data_load = '0; ce = 1'b0; up_down = 1'b1;
    sat_mode = 1'b0; max_val = 8'd255; step = 8'd1; clr_flags = 1'b0;
    #22;
    chk("rst_count", count_out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_tc", tc, 0);
    chk("rst_err", step_err, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_unf", unf_flag, 0);
    rst_n = 1'b1;

    // Reset mid-count
    max_val = 8'd99;
    load(8'd5);
    chk("pre_rst_count", count_out, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count_out, 0);
    chk("async_rst_zero", zero, 1);
    rst_n = 1'b1;
    load(8'd200);
    chk("load_clamp", count_out, 99);
    chk("load_clamp_max", max_count, 1);

    // Wrap up
    max_val = 8'd9; step = 8'd3; up_down = 1'b1; sat_mode = 1'b0;
    load(8'd0);
    ce = 1'b1;
    tick(); chk("wu_3", count_out, 3); chk("wu_3_tc", tc, 0);
    tick(); chk("wu_6", count_out, 6);
    tick(); chk("wu_9", count_out, 9); chk("wu_9_max", max_count, 1);
    tick(); chk("wu_2", count_out, 2); chk("wu_2_tc", tc, 1); chk("wu_2_ovf", ovf_flag, 1);
    tick(); chk("wu_5", count_out, 5); chk("wu_5_tc", tc, 0); chk("wu_5_ovf", ovf_flag, 1);
    ce = 1'b0; clr_flags = 1'b1;
    tick(); chk("clr_ovf", ovf_flag, 0); chk("hold_5", count_out, 5);
    clr_flags = 1'b0;

    // Saturate down
    step = 8'd4; up_down = 1'b0; sat_mode = 1'b1;
    load(8'd5);
    ce = 1'b1;
    tick(); chk("sd_1", count_out, 1); chk("sd_1_unf", unf_flag, 0);
    tick(); chk("sd_0", count_out, 0); chk("sd_0_tc", tc, 1); chk("sd_0_unf", unf_flag, 1);
    tick(); chk("sd_0b", count_out, 0); chk("sd_0b_tc", tc, 1); chk("sd_zero", zero, 1);
    ce = 1'b0; clr_flags = 1'b1;
    tick(); chk("clr_unf", unf_flag, 0); chk("hold_tc", tc, 0);
    clr_flags = 1'b0;

    // Saturate up at max: tc repeats
    step = 8'd4; up_down = 1'b1;
    load(8'd8);
    ce = 1'b1;
    tick(); chk("su_9", count_out, 9); chk("su_9_tc", tc, 1);
    tick(); chk("su_9b", count_out, 9); chk("su_9b_tc", tc, 1);
    ce = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Wrap down, then overflow on the same edge as clr_flags
    step = 8'd3; up_down = 1'b0; sat_mode = 1'b0;
    load(8'd1);
    ce = 1'b1;
    tick(); chk("wd_8", count_out, 8); chk("wd_8_tc", tc, 1); chk("wd_8_unf", unf_flag, 1);
    up_down = 1'b1; clr_flags = 1'b1;
    tick(); chk("wd_up_1", count_out, 1); chk("set_wins_ovf", ovf_flag, 1);
    chk("clr_unf2", unf_flag, 0); chk("wd_up_tc", tc, 1);
    clr_flags = 1'b0;

    // Illegal step
    step = 8'd12;
    tick(); chk("ill_hold", count_out, 1); chk("ill_err", step_err, 1); chk("ill_tc", tc, 0);
    chk("ill_ovf", ovf_flag, 1);
    ce = 1'b0;
    tick(); chk("ill_err_drop", step_err, 0);

    // Runtime max lowered below count
    step = 8'd1;
    load(8'd8);
    max_val = 8'd5; up_down = 1'b0; ce = 1'b1;
    tick(); chk("oor_dn_5", count_out, 5); chk("oor_dn_tc", tc, 0); chk("oor_dn_unf", unf_flag, 0);
    ce = 1'b0; max_val = 8'd9;
    load(8'd8);
    max_val = 8'd5; up_down = 1'b1; ce = 1'b1;
    tick(); chk("oor_up_0", count_out, 0); chk("oor_up_tc", tc, 1);

    // max_val = 0: any nonzero step is illegal
    max_val = 8'd0;
    tick(); chk("m0_count", count_out, 0); chk("m0_err", step_err, 1);

    // Full binary range wrap
    ce = 1'b0; max_val = 8'd255; step = 8'd1; up_down = 1'b1;
    load(8'd255);
    ce = 1'b1;
    tick(); chk("bin_wrap", count_out, 0); chk("bin_wrap_tc", tc, 1);
    up_down = 1'b0;
    tick(); chk("bin_unwrap", count_out, 255); chk("bin_unwrap_tc", tc, 1);

    // Load beats count
    up_down = 1'b1; ce = 1'b1; load_n = 1'b0; data_load = 8'd7;
    tick(); chk("ld_prio", count_out, 7); chk("ld_prio_tc", tc, 0);
    load_n = 1'b1; ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("hold_7", count_out, 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
